// File: rtl/sysmon_pkg.sv
// Shared state encoding and defaults for the sysmon frame sequencer.
// CSUM exists only when SYSMON_FRAME_CHECKSUM_EN is defined.
package sysmon_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef SYSMON_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SYNC, HDR, FETCH, DATA, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, HDR, FETCH, DATA, DONE} state_t;
`endif

endpackage

// File: rtl/sysmon_byte_sender.sv
// One UART byte per request: load pulse, one guard cycle, then wait for busy low.
// Watchdog counts busy-high cycles after the guard; o_timeout fires on reaching TIMEOUT_CYCLES.
module sysmon_byte_sender #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_send,
  input  logic [7:0] i_byte,
  input  logic       i_uart_tx_busy,
  output logic [7:0] o_uart_data,
  output logic       o_uart_wr,
  output logic       o_done,
  output logic       o_timeout
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_MAX   = '1;

  typedef enum logic [1:0] {PH_IDLE, PH_LOAD, PH_GUARD, PH_WAIT} phase_t;

  phase_t         r_phase, w_phase_nxt;
  logic [WDW-1:0] r_wdog;
  logic [7:0]     r_data;

  assign o_uart_wr   = (r_phase == PH_LOAD);
  assign o_uart_data = r_data;
  assign o_timeout   = (r_phase == PH_WAIT) && (r_wdog >= WD_LIMIT);
  assign o_done      = (r_phase == PH_WAIT) && !i_uart_tx_busy && !o_timeout;

  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_IDLE:  if (i_send && !i_uart_tx_busy) w_phase_nxt = PH_LOAD;
      PH_LOAD:  w_phase_nxt = PH_GUARD;
      PH_GUARD: w_phase_nxt = PH_WAIT;
      PH_WAIT:  if (o_done || o_timeout) w_phase_nxt = PH_IDLE;
      default:  w_phase_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= PH_IDLE;
      r_wdog  <= '0;
      r_data  <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      if (r_phase == PH_IDLE && w_phase_nxt == PH_LOAD) r_data <= i_byte;
      // The guard cycle is excluded: only WAIT cycles with busy high are counted.
      if (o_uart_wr)
        r_wdog <= '0;
      else if (r_phase == PH_WAIT && i_uart_tx_busy && r_wdog != WD_MAX)
        r_wdog <= r_wdog + 1'b1;
    end
  end

endmodule

// File: rtl/sysmon_frame_sequencer.sv
// Sends SYNC, header, PAYLOAD_BYTES bytes from payload memory (plus XOR checksum with
// SYSMON_FRAME_CHECKSUM_EN) over a busy-gated UART; a write is taken only in IDLE.
module sysmon_frame_sequencer
  import sysmon_pkg::*;
#(
  parameter int         PAYLOAD_BYTES  = 4,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1023
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                write,
  input  logic [6:0]                          tx_address,
  output logic                                rd_en,
  output logic [7+$clog2(PAYLOAD_BYTES)-1:0]  rd_addr,
  input  logic [7:0]                          rd_data,
  output logic [7:0]                          uart_data,
  output logic                                uart_wr,
  input  logic                                uart_tx_busy,
  output logic                                frame_busy,
  output logic                                write_done,
  output logic                                timeout_err
);
  localparam int AW   = $clog2(PAYLOAD_BYTES);
  localparam int IDXW = (AW < 1) ? 1 : AW;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PAYLOAD_BYTES - 1);

  state_t          r_state, w_state_nxt;
  logic [6:0]      r_addr;
  logic [IDXW-1:0] r_idx;
  logic [7:0]      r_byte;
  logic            r_rd_wait;
  logic            r_abort;
  logic            w_send, w_done, w_timeout;
  logic [7:0]      w_tx_byte;
`ifdef SYSMON_FRAME_CHECKSUM_EN
  logic [7:0]      r_csum;
`endif

  sysmon_byte_sender #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_sender (
    .clk            (clk),
    .reset          (reset),
    .i_send         (w_send),
    .i_byte         (w_tx_byte),
    .i_uart_tx_busy (uart_tx_busy),
    .o_uart_data    (uart_data),
    .o_uart_wr      (uart_wr),
    .o_done         (w_done),
    .o_timeout      (w_timeout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_send      = 1'b0;
    w_tx_byte   = 8'h00;
    case (r_state)
      IDLE:  if (write) w_state_nxt = SYNC;
      SYNC: begin
        w_send    = 1'b1;
        w_tx_byte = SYNC_BYTE;
        if (w_done) w_state_nxt = HDR;
      end
      HDR: begin
        w_send    = 1'b1;
        w_tx_byte = {1'b0, r_addr};
        if (w_done) w_state_nxt = FETCH;
      end
      FETCH: if (r_rd_wait) w_state_nxt = DATA;
      DATA: begin
        w_send    = 1'b1;
        w_tx_byte = r_byte;
        if (w_done) begin
          if (r_idx < LAST_IDX) w_state_nxt = FETCH;
`ifdef SYSMON_FRAME_CHECKSUM_EN
          else                  w_state_nxt = CSUM;
`else
          else                  w_state_nxt = DONE;
`endif
        end
      end
`ifdef SYSMON_FRAME_CHECKSUM_EN
      CSUM: begin
        w_send    = 1'b1;
        w_tx_byte = r_csum;
        if (w_done) w_state_nxt = DONE;
      end
`endif
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) w_state_nxt = DONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_idx     <= '0;
      r_byte    <= '0;
      r_rd_wait <= 1'b0;
      r_abort   <= 1'b0;
`ifdef SYSMON_FRAME_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (write) begin
          r_addr  <= tx_address;
          r_idx   <= '0;
          r_abort <= 1'b0;
`ifdef SYSMON_FRAME_CHECKSUM_EN
          r_csum  <= '0;
`endif
        end
`ifdef SYSMON_FRAME_CHECKSUM_EN
        HDR: if (w_done) r_csum <= r_csum ^ {1'b0, r_addr};
`endif
        FETCH: begin
          r_rd_wait <= !r_rd_wait;
          if (r_rd_wait) r_byte <= rd_data;
        end
        DATA: if (w_done) begin
`ifdef SYSMON_FRAME_CHECKSUM_EN
          r_csum <= r_csum ^ r_byte;
`endif
          if (r_idx < LAST_IDX) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
      if (w_timeout) r_abort <= 1'b1;
    end
  end

  assign frame_busy  = (r_state != IDLE);
  assign write_done  = (r_state == DONE);
  assign timeout_err = write_done && r_abort;
  assign rd_en       = (r_state == FETCH) && !r_rd_wait;

  generate
    if (AW == 0) begin : g_addr_only
      assign rd_addr = r_addr;
    end else begin : g_addr_idx
      assign rd_addr = {r_addr, r_idx[AW-1:0]};
    end
  endgenerate

endmodule

// File: doc/sysmon_frame_sequencer.md
SYSMON_FRAME_SEQUENCER -- requirements
Module: sysmon_frame_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- PAYLOAD_BYTES, 4, payload bytes per frame; power of two, 1..16.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- TIMEOUT_CYCLES, 1023, maximum cycles uart_tx_busy may stay high per byte.

REQ-002 The block SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- write  in  1  frame request pulse from the channel arbiter.
- tx_address  in  7  channel address; sampled when write is accepted.
- rd_en  out  1  payload memory read strobe.
- rd_addr  out  7+$clog2(PAYLOAD_BYTES)  read address, {latched address, byte index}.
- rd_data  in  8  payload byte; valid exactly 1 cycle after rd_en.
- uart_data  out  8  byte to transmit.
- uart_wr  out  1  one-cycle byte-load strobe to the UART.
- uart_tx_busy  in  1  UART busy; rises no later than 1 cycle after uart_wr.
- frame_busy  out  1  high whenever the FSM is not in IDLE.
- write_done  out  1  one-cycle pulse at frame end, whether the frame completed or aborted.
- timeout_err  out  1  one-cycle pulse on abort; coincident with write_done.

Function
REQ-003 The FSM SHALL have these states: IDLE, SYNC, HDR, FETCH, DATA, CSUM, DONE.
REQ-004 IDLE SHALL accept write by latching tx_address, clearing byte_idx and the checksum, and moving to SYNC.
REQ-005 write asserted outside IDLE SHALL be ignored; no request is queued.
REQ-006 The frame byte order SHALL be: SYNC_BYTE, {1'b0, tx_address}, payload[0..PAYLOAD_BYTES-1], then the checksum byte when enabled (REQ-016).
REQ-007 Byte send handshake:
- In a sending state, with no send outstanding and uart_tx_busy low, the block SHALL drive uart_data and pulse uart_wr for 1 cycle.
- It SHALL ignore uart_tx_busy for the next cycle (guard).
- It SHALL then wait for uart_tx_busy low before the next transition.
REQ-008 FETCH SHALL pulse rd_en with rd_addr = {addr, byte_idx} for 1 cycle, then capture rd_data 1 cycle later and go to DATA.
REQ-009 After each payload byte completes, DATA SHALL increment byte_idx. It SHALL return to FETCH while byte_idx < PAYLOAD_BYTES-1, else go to CSUM or DONE.
REQ-010 byte_idx SHALL be $clog2(PAYLOAD_BYTES) bits wide, with a minimum of 1. It SHALL never wrap within a frame.
REQ-011 DONE SHALL pulse write_done for 1 cycle and return to IDLE in the next cycle.
REQ-012 Minimum write-to-write turnaround: the next write SHALL be accepted from the cycle after DONE.
REQ-013 A per-byte watchdog SHALL count cycles with uart_tx_busy high after the guard cycle. Reaching TIMEOUT_CYCLES SHALL abort the frame: pulse timeout_err and write_done together, then return to IDLE.
REQ-014 The watchdog counter SHALL clear on each uart_wr. It SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and saturating.

Reset
REQ-015 On reset (asynchronous assert, synchronous release):
- FSM in IDLE.
- uart_wr, rd_en, write_done, timeout_err, frame_busy all 0.
- uart_data 8'h00, rd_addr 0, byte_idx 0, checksum 0, watchdog 0.
- A frame in progress SHALL be dropped with no write_done.

Configuration
REQ-016 With SYSMON_FRAME_CHECKSUM_EN defined:
- The block SHALL XOR the header and every payload byte into an 8-bit checksum.
- It SHALL send the checksum in CSUM after the last payload byte, then go to DONE.
- The sync byte SHALL NOT be included in the checksum.
REQ-017 Without SYSMON_FRAME_CHECKSUM_EN, the CSUM state and the checksum register SHALL be absent. The last payload byte SHALL go directly to DONE.

Structure
REQ-018 A shared package sysmon_pkg SHALL hold the FSM state enum typedef and the default SYNC_BYTE constant.
REQ-019 The per-byte handshake plus watchdog SHALL be one sub-module, sysmon_byte_sender. It takes a send request and a byte, and returns done and timeout.

Verification
REQ-020 PAYLOAD_BYTES=4, checksum on, write with tx_address=7'h05, memory bytes 11,22,33,44:
- Required: uart bytes A5,05,11,22,33,44,41.
- Required: rd_addr 9'h014..9'h017.
- Required: exactly one write_done.
REQ-021 Same stimulus, checksum off:
- Required: bytes A5,05,11,22,33,44.
- Required: write_done 1 cycle after uart_tx_busy falls following byte 44.
REQ-022 Hold uart_tx_busy high during the HDR byte for 1023 cycles after guard:
- Required: timeout_err=1 and write_done=1 in the same cycle.
- Required: frame_busy=0 in the following cycle.
REQ-023 Pulse write with 7'h09 during DATA of a 7'h05 frame:
- Required: no effect.
- Required: only the 7'h05 frame is sent.
REQ-024 Assert reset during DATA byte 2:
- Required: uart_wr=0 immediately.
- Required: no write_done.
- Required: the next write after release sends a complete fresh frame starting with A5.
REQ-025 PAYLOAD_BYTES=1, uart_tx_busy tied low:
- Required: frame A5,addr,byte,(csum).
- Required: a write in the cycle after the write_done pulse is accepted.
